cac_fns_seq_decoder_7: RTL and testbench

CAC_FNS_SEQ_DECODER_7 -- requirements
Module: cac_fns_seq_decoder_7

---
 rtl/cac_fns_pkg.sv | 31 +++
 rtl/cac_ftf_check.sv | 24 ++
 rtl/cac_fns_seq_decoder_7.sv | 122 ++++++++++++
 tb/tb_cac_fns_seq_decoder_7.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cac_fns_pkg.sv
// Shared FNS (Fibonacci numeral system) definitions for the coder and decoder sides.
// Holds the default word widths, the FNS weight table and the decoder FSM state enum.
package cac_fns_pkg;

    localparam int unsigned FNS_BLEN  = 6;  // decoded word width (FNS range 0..33)
    localparam int unsigned FNS_NTSV  = 7;  // TSV codeword width
    localparam int unsigned FNS_CNT_W = 3;  // bit-index counter width (0..6)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } fns_state_e;

    // FNS weight of codeword bit k: W[6:0] = 13,8,5,3,2,1,1
    function automatic logic [FNS_BLEN-1:0] fns_weight(input logic [FNS_CNT_W-1:0] k);
        logic [FNS_BLEN-1:0] w;
        case (k)
            3'd0:    w = 6'd1;
            3'd1:    w = 6'd1;
            3'd2:    w = 6'd2;
            3'd3:    w = 6'd3;
            3'd4:    w = 6'd5;
            3'd5:    w = 6'd8;
            3'd6:    w = 6'd13;
            default: w = 6'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cac_ftf_check.sv
// Forbidden-transition-free rule check on an FNS codeword (combinational).
// Ports:
//   tsv       in  NTSV  codeword, bit 0 = LSB weight
//   ftf_err_c out 1     an odd bit is set without both of its neighbours set
module cac_ftf_check
    import cac_fns_pkg::*;
#(
    parameter int unsigned NTSV = FNS_NTSV
) (
    input  logic [NTSV-1:0] tsv,
    output logic            ftf_err_c
);

    // Each odd, interior bit that is 1 needs both neighbours to be 1 as well.
    always_comb begin
        ftf_err_c = 1'b0;
        for (int unsigned k = 1; k + 1 < NTSV; k += 2) begin
            if (tsv[k] && !(tsv[k+1] && tsv[k-1])) begin
                ftf_err_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cac_fns_seq_decoder_7.sv
// Bit-serial FNS decoder for 7-bit TSV codewords.
// A codeword accepted in IDLE is decoded MSB first, one bit per cycle, by
// accumulating FNS weights; the result and its FTF flag are then held until
// downstream consumes them.
// Ports:
//   clock     in  1     rising-edge clock
//   rst_n     in  1     asynchronous active-low reset
//   tsv_in    in  NTSV  received codeword
//   in_valid  in  1     tsv_in holds a codeword
//   in_ready  out 1     decoder accepts a codeword this cycle
//   data_out  out BLEN  decoded word
//   out_valid out 1     data_out / ftf_err valid
//   out_ready in  1     downstream consumes the result
//   ftf_err   out 1     captured codeword broke the FTF rule
module cac_fns_seq_decoder_7
    import cac_fns_pkg::*;
#(
    parameter int unsigned BLEN = FNS_BLEN,
    parameter int unsigned NTSV = FNS_NTSV  // only 7 is supported
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic [NTSV-1:0] tsv_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BLEN-1:0] data_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            ftf_err
);

    fns_state_e            state;
    fns_state_e            next_state;
    logic                  accept_c;
    logic                  ftf_c;
    logic [NTSV-1:0]       sreg;
    logic [BLEN-1:0]       acc;
    logic [FNS_CNT_W-1:0]  cnt;
    logic                  ftf_cap;

    cac_ftf_check #(
        .NTSV (NTSV)
    ) u_ftf_check (
        .tsv       (tsv_in),
        .ftf_err_c (ftf_c)
    );

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE exits only once the registered result has been seen
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            ftf_err   <= 1'b0;
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            ftf_cap   <= 1'b0;
        end else begin
            in_ready <= (next_state == IDLE);
            if (accept_c) begin
                sreg    <= tsv_in;
                acc     <= '0;
                cnt     <= FNS_CNT_W'(NTSV - 1);
                ftf_cap <= ftf_c;
            end else if (state == DECODE) begin
                // sreg MSB always holds original bit 'cnt'
                if (sreg[NTSV-1]) begin
                    acc <= acc + BLEN'(fns_weight(cnt));
                end
                sreg <= {sreg[NTSV-2:0], 1'b0};
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == DONE) begin
                // First DONE cycle publishes the result; it then holds until consumed
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    data_out  <= acc;
                    ftf_err   <= ftf_cap;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cac_fns_seq_decoder_7.sv
// Directed self-checking bench for cac_fns_seq_decoder_7.
module tb_cac_fns_seq_decoder_7;

    logic       clock;
    logic       rst_n;
    logic [6:0] tsv_in;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       ftf_err;

    int n_checks;
    int n_fail;

    cac_fns_seq_decoder_7 dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .tsv_in    (tsv_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ftf_err   (ftf_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: weighted sum and FTF rule
    function automatic int ref_val(input logic [6:0] v);
        int w[7];
        int s;
        w = '{1, 1, 2, 3, 5, 8, 13};
        s = 0;
        for (int k = 0; k < 7; k++) if (v[k]) s += w[k];
        return s;
    endfunction

    function automatic logic ref_ftf(input logic [6:0] v);
        logic r;
        r = 1'b0;
        for (int k = 1; k <= 5; k += 2)
            if (v[k] && (!v[k+1] || !v[k-1])) r = 1'b1;
        return r;
    endfunction

    // Accept v when ready, then wait for out_valid. Starts and ends just after a negedge.
    // scramble drives a different codeword with in_valid high during the decode.
    task automatic run_decode(input logic [6:0] v, input bit scramble,
                              output logic [5:0] d, output logic e, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clock);
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end
        tsv_in   = v;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (scramble) begin
            tsv_in = ~v;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        d = data_out;
        e = ftf_err;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tsv_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== 6'd0 || ftf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b d=%0d e=%0b required v=0 d=0 e=0",
                     out_valid, data_out, ftf_err);
        end
        rst_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [6:0] tv[5];
        int         dv[5];
        logic       fv[5];
        logic [5:0] d;
        logic       e;
        int         lat;
        tv[0] = 7'b0000000; dv[0] = 0;  fv[0] = 1'b0;
        tv[1] = 7'b1111111; dv[1] = 33; fv[1] = 1'b0;
        tv[2] = 7'b0000111; dv[2] = 4;  fv[2] = 1'b0;
        tv[3] = 7'b0000010; dv[3] = 1;  fv[3] = 1'b1;
        tv[4] = 7'b0101000; dv[4] = 11; fv[4] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_decode(tv[i], 1'b0, d, e, lat);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL latency tsv=%b got %0d edges required 8", tv[i], lat);
            end
            n_checks++;
            if (d !== 6'(dv[i]) || e !== fv[i]) begin
                n_fail++;
                $display("FAIL vector tsv=%b got d=%0d e=%0b required d=%0d e=%0b",
                         tv[i], d, e, dv[i], fv[i]);
            end
        end
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [5:0] d;
        logic       e;
        int         lat;
        out_ready = 1'b0;
        run_decode(7'b1010101, 1'b0, d, e, lat);
        // inputs are live during DONE and must be ignored
        tsv_in   = 7'b1111111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || data_out !== 6'd21 || ftf_err !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d got v=%0b d=%0d e=%0b rdy=%0b required 1/21/0/0",
                         i, out_valid, data_out, ftf_err, in_ready);
            end
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release got v=%0b rdy=%0b required 0/1", out_valid, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_ignore_mid_decode();
        logic [5:0] d;
        logic       e;
        int         lat;
        out_ready = 1'b0;
        run_decode(7'b0000111, 1'b1, d, e, lat);
        n_checks++;
        if (d !== 6'd4 || e !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_mid got d=%0d e=%0b lat=%0d required 4/0/8", d, e, lat);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] d;
        logic       e;
        int         lat;
        bit         seen;
        wait (in_ready === 1'b1);
        @(negedge clock);
        tsv_in   = 7'b1111111;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== 6'd0 || ftf_err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got v=%0b d=%0d e=%0b rdy=%0b required 0/0/0/1",
                     out_valid, data_out, ftf_err, in_ready);
        end
        @(negedge clock);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard got out_valid seen=%0b required 0", seen);
        end
        out_ready = 1'b1;
        run_decode(7'b1111111, 1'b0, d, e, lat);
        n_checks++;
        if (d !== 6'd33 || e !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL reset_recover got d=%0d e=%0b lat=%0d required 33/0/8", d, e, lat);
        end
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] d;
        logic       e;
        int         lat;
        logic [6:0] v;
        out_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            run_decode(v, 1'b0, d, e, lat);
            n_checks++;
            if (d !== 6'(ref_val(v)) || e !== ref_ftf(v) || lat !== 8) begin
                n_fail++;
                $display("FAIL all_codes tsv=%b got d=%0d e=%0b lat=%0d required d=%0d e=%0b lat=8",
                         v, d, e, lat, ref_val(v), ref_ftf(v));
            end
        end
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_ignore_mid_decode();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
